imem_uart_loader: RTL and testbench



---
 rtl/imem_uart_loader_pkg.sv | 26 ++
 rtl/imem_uart_loader_if.sv | 39 +++
 rtl/imem_uart_loader_idle_timeout.sv | 44 ++++
 rtl/imem_uart_loader.sv | 135 +++++++++++++
 tb/tb_imem_uart_loader.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : loader_pkg
// Purpose : Shared types and constants for the UART instruction-memory loader.
//           Holds the frame FSM state type, the default frame start marker,
//           the word count that a zero count byte stands for, and the write
//           latency (cycles from the last byte of a word to the RAM write).
// Revision: 1.0 - initial release
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_COUNT = 3'd1,
    LD_DATA  = 3'd2,
    LD_CHECK = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERROR = 3'd5
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
  localparam int         COUNT_ZERO_WORDS  = 256;
  localparam int         WRITE_LATENCY     = 1;

endpackage
`default_nettype wire

// File: rtl/imem_uart_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : imem_uart_loader_if
// Purpose : Byte stream from the UART receiver plus the instruction RAM
//           write port, bundled for the loader.
// Ports   : rx_data/rx_valid   - received byte and its one-cycle strobe
//           imem_we            - one-cycle RAM write enable
//           imem_addr          - byte address of the word being written
//           imem_wdata         - instruction word being written
// Modports: master - byte source / RAM side (drives rx_*, observes imem_*)
//           slave  - the loader (observes rx_*, drives imem_*)
// Revision: 1.0 - initial release
// ============================================================================
interface imem_uart_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/imem_uart_loader_idle_timeout.sv
`default_nettype none
// ============================================================================
// Module  : idle_timeout
// Purpose : Counts idle cycles between received bytes while a frame is in
//           progress and flags when the gap reaches TIMEOUT_CYCLES.
// Ports   : clk     - system clock
//           reset   - asynchronous active-low reset
//           enable  - counting allowed (frame in progress)
//           kick    - a byte arrived this cycle; restarts the gap count
//           expired - gap has reached TIMEOUT_CYCLES in this cycle
// Revision: 1.0 - initial release
// ============================================================================
module idle_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // count holds the number of idle cycles already completed since the last
  // byte, so the current cycle is idle cycle count+1. Expiry is flagged in the
  // idle cycle that makes the gap TIMEOUT_CYCLES long. A byte in that same
  // cycle masks expiry, so the byte wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (kick || !enable) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && !kick && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_uart_loader
// Purpose : Boot-time instruction memory writer. Receives a framed program
//           image (sync, count, N big-endian words, XOR checksum) from the
//           UART receiver, writes each word to consecutive RAM word addresses
//           and holds the core in reset until a frame with a good checksum
//           has been loaded.
// Ports   : clk        - system clock
//           reset      - asynchronous active-low reset
//           bus        - slave side of imem_uart_loader_if (rx bytes in,
//                        RAM write port out)
//           cpu_hold   - keeps the core in reset while high
//           load_done  - a frame loaded successfully
//           load_error - the last frame failed (checksum or timeout)
// Revision: 1.0 - initial release
// ============================================================================
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WORDS     = 256,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_uart_loader_if.slave    bus,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_error
);

  localparam int WIDX_W = $clog2(ADDR_WORDS);

  localparam logic [2:0] ST_IDLE  = LD_IDLE;
  localparam logic [2:0] ST_COUNT = LD_COUNT;
  localparam logic [2:0] ST_DATA  = LD_DATA;
  localparam logic [2:0] ST_CHECK = LD_CHECK;
  localparam logic [2:0] ST_DONE  = LD_DONE;
  localparam logic [2:0] ST_ERROR = LD_ERROR;

  logic [2:0]        state;
  logic [WIDX_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [7:0]        acc;
  logic [23:0]       shift;      // first three bytes of the word in progress
  logic [8:0]        words_left;
  logic              in_frame;
  logic              expired;

  assign in_frame = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CHECK);

  idle_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (in_frame),
    .kick   (bus.rx_valid),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      word_idx       <= '0;
      byte_idx       <= '0;
      acc            <= '0;
      shift          <= '0;
      words_left     <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_hold       <= 1'b1;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      if (bus.rx_valid) begin
        case (state)
          ST_IDLE, ST_ERROR: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state      <= ST_COUNT;
              word_idx   <= '0;
              byte_idx   <= '0;
              acc        <= '0;
              load_error <= 1'b0;
            end
          end
          ST_COUNT: begin
            words_left <= (bus.rx_data == 8'd0) ? 9'(COUNT_ZERO_WORDS)
                                                : {1'b0, bus.rx_data};
            state      <= ST_DATA;
          end
          ST_DATA: begin
            acc      <= acc ^ bus.rx_data;
            shift    <= {shift[15:0], bus.rx_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= 32'({word_idx, 2'b00});
              bus.imem_wdata <= {shift, bus.rx_data};
              words_left     <= words_left - 9'd1;
              // The index only advances when another word follows, so a full
              // 256-word frame never wraps it back to zero.
              if (words_left == 9'd1) begin
                state <= ST_CHECK;
              end else begin
                word_idx <= word_idx + WIDX_W'(1);
              end
            end
          end
          ST_CHECK: begin
            if (bus.rx_data == acc) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ST_ERROR;
              load_error <= 1'b1;
            end
          end
          default: begin
            // DONE is terminal until reset; bytes are ignored.
          end
        endcase
      end else if (expired) begin
        state      <= ST_ERROR;
        load_error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_uart_loader
// Purpose : Self-checking bench for imem_uart_loader. Frames are built from
//           word arrays; expected RAM writes and final status are derived
//           from the frame contents (address = 4*i, data = word i, done when
//           the checksum byte equals the XOR of all data bytes).
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_uart_loader;

  logic clk;
  logic reset;
  logic cpu_hold;
  logic load_done;
  logic load_error;

  imem_uart_loader_if bus ();

  imem_uart_loader #(
    .ADDR_WORDS    (256),
    .TIMEOUT_CYCLES(16),
    .SYNC_BYTE     (8'h55)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] fw [256];
  logic [7:0]  dir_bytes [15];
  logic [31:0] dir_words [3];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    idle(1);
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Sends a frame carrying fw[0..n-1]; count byte is n mod 256.
  task automatic send_frame(input int n, input bit corrupt, input int maxgap);
    logic [7:0] cks;
    cks = 8'h00;
    send_byte(8'h55);
    if (maxgap > 0) idle($urandom_range(0, maxgap));
    send_byte(n[7:0]);
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        logic [7:0] b;
        b = fw[i][8*k +: 8];
        cks = cks ^ b;
        if (maxgap > 0) idle($urandom_range(0, maxgap));
        send_byte(b);
      end
    end
    if (maxgap > 0) idle($urandom_range(0, maxgap));
    send_byte(corrupt ? (cks ^ 8'h01) : cks);
  endtask

  task automatic check_writes(input string tag, input int n);
    int m;
    chk({tag, "_wr_count"}, wr_addr.size(), n);
    m = (wr_addr.size() < n) ? wr_addr.size() : n;
    for (int i = 0; i < m; i++) begin
      chk({tag, "_wr_addr"}, wr_addr[i], 32'(i * 4));
      chk({tag, "_wr_data"}, wr_data[i], fw[i]);
    end
  endtask

  task automatic check_status(input string tag, input bit done);
    chk({tag, "_done"},  32'(load_done),  32'(done));
    chk({tag, "_error"}, 32'(load_error), 32'(!done));
    chk({tag, "_hold"},  32'(cpu_hold),   32'(!done));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b0;

    // ---------------- reset values ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold",  32'(cpu_hold),   32'd1);
    chk("rst_done",  32'(load_done),  32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_we",    32'(bus.imem_we), 32'd0);
    chk("rst_addr",  bus.imem_addr,   32'd0);
    chk("rst_wdata", bus.imem_wdata,  32'd0);
    #2;
    reset = 1'b1;
    idle(1);

    // ---------------- noise in IDLE ----------------
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(20);
    chk("noise_wr_count", wr_addr.size(), 0);
    chk("noise_hold",  32'(cpu_hold),   32'd1);
    chk("noise_done",  32'(load_done),  32'd0);
    chk("noise_error", 32'(load_error), 32'd0);

    // ---------------- directed good 3-word frame ----------------
    {dir_bytes[0], dir_bytes[1], dir_bytes[2], dir_bytes[3], dir_bytes[4]} =
        {8'h55, 8'h03, 8'h08, 8'h00, 8'h00};
    {dir_bytes[5], dir_bytes[6], dir_bytes[7], dir_bytes[8], dir_bytes[9]} =
        {8'h03, 8'h08, 8'h00, 8'h00, 8'h2e};
    {dir_bytes[10], dir_bytes[11], dir_bytes[12], dir_bytes[13], dir_bytes[14]} =
        {8'h08, 8'h00, 8'h00, 8'h76, 8'h53};
    dir_words[0] = 32'h08000003;
    dir_words[1] = 32'h0800002e;
    dir_words[2] = 32'h08000076;
    for (int i = 0; i < 3; i++) fw[i] = dir_words[i];
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send_byte(dir_bytes[i]);
      if (i == 5 || i == 9 || i == 13) begin
        chk("dir_we_pulse", 32'(bus.imem_we), 32'd1);
        chk("dir_addr",     bus.imem_addr,   32'((i - 5) / 4 * 4));
        chk("dir_wdata",    bus.imem_wdata,  dir_words[(i - 5) / 4]);
      end
      if (i == 6) chk("dir_we_drop", 32'(bus.imem_we), 32'd0);
      if (i == 13) chk("dir_hold_before_cks", 32'(cpu_hold), 32'd1);
    end
    check_status("dir_good", 1'b1);
    idle(2);
    check_writes("dir_good", 3);

    // ---------------- bad checksum, then resend ----------------
    do_reset();
    for (int i = 0; i < 14; i++) send_byte(dir_bytes[i]);
    send_byte(8'h54);
    check_status("dir_bad", 1'b0);
    idle(2);
    check_writes("dir_bad", 3);
    wr_addr.delete();
    wr_data.delete();
    send_byte(8'h55);
    chk("restart_error_clear", 32'(load_error), 32'd0);
    for (int i = 1; i < 15; i++) send_byte(dir_bytes[i]);
    check_status("resend", 1'b1);
    idle(2);
    check_writes("resend", 3);

    // ---------------- randomized frames ----------------
    for (int t = 0; t < 8; t++) begin
      int n;
      bit corrupt;
      n = $urandom_range(1, 12);
      corrupt = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < n; i++) fw[i] = $urandom();
      do_reset();
      send_frame(n, corrupt, 3);
      check_status("rand", !corrupt);
      idle(2);
      check_writes("rand", n);
    end

    // ---------------- 256 words back-to-back ----------------
    for (int i = 0; i < 256; i++) fw[i] = $urandom();
    do_reset();
    send_frame(256, 1'b0, 0);
    check_status("full", 1'b1);
    idle(2);
    check_writes("full", 256);
    begin
      int zeros;
      zeros = 0;
      foreach (wr_addr[i]) if (wr_addr[i] == 32'd0) zeros++;
      chk("full_addr0_writes", zeros, 1);
      if (wr_addr.size() > 0) chk("full_last_addr", wr_addr[wr_addr.size() - 1], 32'h3FC);
    end

    // ---------------- timeout ----------------
    do_reset();
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h08);
    send_byte(8'h00);
    idle(15);
    chk("tmo_before", 32'(load_error), 32'd0);
    idle(1);
    chk("tmo_fire",  32'(load_error), 32'd1);
    chk("tmo_hold",  32'(cpu_hold),   32'd1);
    chk("tmo_wr_count", wr_addr.size(), 0);

    // byte in the expiry cycle keeps the frame alive
    do_reset();
    fw[0] = 32'h08000000;
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h08);
    send_byte(8'h00);
    idle(15);
    send_byte(8'h00);
    idle(3);
    chk("tmo_saved", 32'(load_error), 32'd0);
    send_byte(8'h00);
    send_byte(8'h08);
    check_status("tmo_saved", 1'b1);
    idle(2);
    check_writes("tmo_saved", 1);

    // ---------------- reset mid-frame ----------------
    for (int i = 0; i < 3; i++) fw[i] = $urandom();
    do_reset();
    send_byte(8'h55);
    send_byte(8'h03);
    for (int k = 3; k >= 0; k--) send_byte(fw[0][8*k +: 8]);
    chk("midrst_we_before", 32'(bus.imem_we), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_we",    32'(bus.imem_we),  32'd0);
    chk("midrst_addr",  bus.imem_addr,     32'd0);
    chk("midrst_wdata", bus.imem_wdata,    32'd0);
    chk("midrst_hold",  32'(cpu_hold),     32'd1);
    idle(3);
    chk("midrst_wr_count", wr_addr.size(), 0);
    do_reset();
    send_frame(3, 1'b0, 2);
    check_status("after_midrst", 1'b1);
    idle(2);
    check_writes("after_midrst", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
